// File: rtl/ring_router_arbiter_if.sv
// Handshake bundle between the ring router arbiter and its surroundings.
// The master modport is the flit source/sink side; the slave modport is the arbiter itself.
interface ring_router_arbiter_if;
    logic ring_valid;
    logic ring_first;
    logic ring_last;
    logic ring_ready;
    logic local_valid;
    logic local_first;
    logic local_last;
    logic local_ready;
    logic out_valid;
    logic out_ready;
    logic sel_ring;
    logic sel_local;
    logic err_orphan;

    modport master (
        output ring_valid, ring_first, ring_last,
        output local_valid, local_first, local_last,
        output out_ready,
        input  ring_ready, local_ready, out_valid, sel_ring, sel_local, err_orphan
    );

    modport slave (
        input  ring_valid, ring_first, ring_last,
        input  local_valid, local_first, local_last,
        input  out_ready,
        output ring_ready, local_ready, out_valid, sel_ring, sel_local, err_orphan
    );
endinterface

// File: rtl/ring_router_arbiter.sv
// Worm-granular arbiter for the ring router output mux. Picks a ring or local worm in IDLE,
// locks it until its last flit, and steers the external data mux via sel_ring/sel_local.
// Ring has priority, but a waiting local worm gets a slot after RING_BURST contested ring worms.
// Optional per-source completed-worm counters are built when RING_ROUTER_ARB_STATS_EN is defined.
module ring_router_arbiter #(
    parameter int unsigned RING_BURST = 4
`ifdef RING_ROUTER_ARB_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ring_router_arbiter_if.slave    bus
`ifdef RING_ROUTER_ARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [STAT_WIDTH-1:0]   stat_ring_worms,
    output logic [STAT_WIDTH-1:0]   stat_local_worms
`endif
);

    localparam logic [7:0] BURST = 8'(RING_BURST);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WORM_RING  = 2'd1,
        WORM_LOCAL = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] streak_q, streak_d;

    logic rq_r, rq_l;
    logic grant_ring, grant_local;
    logic ring_rdy, local_rdy, out_vld, sel_r, sel_l, orphan;

    assign rq_r = bus.ring_valid & bus.ring_first;
    assign rq_l = bus.local_valid & bus.local_first;

    // Ring wins unless a local worm is also waiting and the ring streak has used up its budget.
    assign grant_ring  = rq_r & (~rq_l | (streak_q < BURST));
    assign grant_local = rq_l & ~grant_ring;

    // State and streak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Arbitration, worm locking, orphan dropping and the combinational handshake outputs.
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        ring_rdy  = 1'b0;
        local_rdy = 1'b0;
        out_vld   = 1'b0;
        sel_r     = 1'b0;
        sel_l     = 1'b0;
        orphan    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_ring) begin
                    sel_r    = 1'b1;
                    out_vld  = 1'b1;
                    ring_rdy = bus.out_ready;
                    if (rq_l && streak_q < BURST) begin
                        streak_d = streak_q + 8'd1;
                    end
                    // Decision is locked even if the first flit is stalled.
                    if (!(bus.ring_last && bus.out_ready)) begin
                        state_d = WORM_RING;
                    end
                end else if (grant_local) begin
                    sel_l     = 1'b1;
                    out_vld   = 1'b1;
                    local_rdy = bus.out_ready;
                    streak_d  = 8'd0;
                    if (!(bus.local_last && bus.out_ready)) begin
                        state_d = WORM_LOCAL;
                    end
                end else if (bus.ring_valid) begin
                    // No first flit anywhere: a valid ring flit here is an orphan.
                    ring_rdy = 1'b1;
                    orphan   = 1'b1;
                end else if (bus.local_valid) begin
                    local_rdy = 1'b1;
                    orphan    = 1'b1;
                end
            end
            WORM_RING: begin
                sel_r    = 1'b1;
                out_vld  = bus.ring_valid;
                ring_rdy = bus.out_ready;
                if (bus.ring_valid && bus.ring_last && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            WORM_LOCAL: begin
                sel_l     = 1'b1;
                out_vld   = bus.local_valid;
                local_rdy = bus.out_ready;
                if (bus.local_valid && bus.local_last && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are held low for the whole time reset is asserted.
    assign bus.ring_ready  = rst_n & ring_rdy;
    assign bus.local_ready = rst_n & local_rdy;
    assign bus.out_valid   = rst_n & out_vld;
    assign bus.sel_ring    = rst_n & sel_r;
    assign bus.sel_local   = rst_n & sel_l;
    assign bus.err_orphan  = rst_n & orphan;

`ifdef RING_ROUTER_ARB_STATS_EN
    logic ring_done, local_done;

    // A worm completes on the handshake of its last flit while it owns the output.
    assign ring_done  = sel_r & bus.ring_valid & ring_rdy & bus.ring_last;
    assign local_done = sel_l & bus.local_valid & local_rdy & bus.local_last;

    // Saturating completed-worm counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ring_worms  <= '0;
            stat_local_worms <= '0;
        end else if (stat_clr) begin
            stat_ring_worms  <= '0;
            stat_local_worms <= '0;
        end else begin
            if (ring_done && stat_ring_worms != '1) begin
                stat_ring_worms <= stat_ring_worms + 1'b1;
            end
            if (local_done && stat_local_worms != '1) begin
                stat_local_worms <= stat_local_worms + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ring_router_arbiter.sv
// Self-checking bench for ring_router_arbiter: directed scenarios plus a randomized run
// compared against a worm-level reference model of the arbitration rules.
module tb_ring_router_arbiter;

    localparam int unsigned RING_BURST = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ring_router_arbiter_if bus();

`ifdef RING_ROUTER_ARB_STATS_EN
    logic       stat_clr;
    logic [1:0] stat_ring_worms;
    logic [1:0] stat_local_worms;

    ring_router_arbiter #(
        .RING_BURST (RING_BURST),
        .STAT_WIDTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .stat_clr         (stat_clr),
        .stat_ring_worms  (stat_ring_worms),
        .stat_local_worms (stat_local_worms)
    );
`else
    ring_router_arbiter #(
        .RING_BURST (RING_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    always #5 clk = ~clk;

    // Output vector: {out_valid, ring_ready, local_ready, sel_ring, sel_local, err_orphan}
    wire [5:0] outs = {bus.out_valid, bus.ring_ready, bus.local_ready,
                       bus.sel_ring, bus.sel_local, bus.err_orphan};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ring_valid  = 1'b0;
        bus.ring_first  = 1'b0;
        bus.ring_last   = 1'b0;
        bus.local_valid = 1'b0;
        bus.local_first = 1'b0;
        bus.local_last  = 1'b0;
        bus.out_ready   = 1'b1;
`ifdef RING_ROUTER_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
    endtask

    task automatic drive(input bit rv, input bit rf, input bit rl,
                         input bit lv, input bit lf, input bit ll, input bit ordy);
        bus.ring_valid  = rv;
        bus.ring_first  = rf;
        bus.ring_last   = rl;
        bus.local_valid = lv;
        bus.local_first = lf;
        bus.local_last  = ll;
        bus.out_ready   = ordy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1, 1, 1);
`ifdef RING_ROUTER_ARB_STATS_EN
        stat_clr = 1'b1;
`endif
        #3;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_async outs got %b want %b", outs, 6'b000000);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_held outs got %b want %b", outs, 6'b000000);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_idle outs got %b want %b", outs, 6'b000000);
        end
        tick();
    endtask

    task automatic test_ring_worm();
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, i == 2, 0, 0, 0, 1);
            #1;
            checks++;
            if (outs !== 6'b110100) begin
                errors++;
                $display("FAIL ring_worm flit%0d outs got %b want %b", i, outs, 6'b110100);
            end
            tick();
        end
        // Back in IDLE: a local first flit must be granted straight away.
        drive(0, 0, 0, 1, 1, 1, 1);
        #1;
        checks++;
        if (outs !== 6'b101010) begin
            errors++;
            $display("FAIL ring_worm_idle outs got %b want %b", outs, 6'b101010);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_burst_order();
        string exp_order;
        byte   got;
        exp_order = "RRRRLRRRRL";
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 1, 1, 1, 1);
            #1;
            got = bus.sel_ring ? "R" : (bus.sel_local ? "L" : "-");
            checks++;
            if (got !== exp_order[i]) begin
                errors++;
                $display("FAIL burst_order grant%0d got %c want %c", i, got, exp_order[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(0, 0, 0, 1, 1, 0, 1);
        #1;
        checks++;
        if (outs !== 6'b101010) begin
            errors++;
            $display("FAIL bp_local_first outs got %b want %b", outs, 6'b101010);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 1, 0, 1, 0);
            #1;
            checks++;
            if (outs !== 6'b100010) begin
                errors++;
                $display("FAIL bp_stall cycle%0d outs got %b want %b", i, outs, 6'b100010);
            end
            tick();
        end
        drive(1, 1, 1, 1, 0, 1, 1);
        #1;
        checks++;
        if (outs !== 6'b101010) begin
            errors++;
            $display("FAIL bp_local_last outs got %b want %b", outs, 6'b101010);
        end
        tick();
        drive(1, 1, 1, 0, 0, 0, 1);
        #1;
        checks++;
        if (outs !== 6'b110100) begin
            errors++;
            $display("FAIL bp_ring_next outs got %b want %b", outs, 6'b110100);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_orphan();
        logic [5:0] exp_tab [6];
        exp_tab = '{6'b010001, 6'b000000, 6'b010001, 6'b001001, 6'b101010, 6'b010001};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       drive(1, 0, 0, 0, 0, 0, 1);
                1:       drive(0, 0, 0, 0, 0, 0, 1);
                2:       drive(1, 0, 1, 1, 0, 0, 1);
                3:       drive(0, 0, 0, 1, 0, 0, 1);
                4:       drive(1, 0, 0, 1, 1, 1, 1);
                default: drive(1, 0, 1, 0, 0, 0, 1);
            endcase
            #1;
            checks++;
            if (outs !== exp_tab[i]) begin
                errors++;
                $display("FAIL orphan step%0d outs got %b want %b", i, outs, exp_tab[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_midworm_reset();
        drive(1, 1, 0, 0, 0, 0, 1);
        #1;
        checks++;
        if (outs !== 6'b110100) begin
            errors++;
            $display("FAIL midreset_first outs got %b want %b", outs, 6'b110100);
        end
        tick();
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 1);
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("FAIL midreset_held outs got %b want %b", outs, 6'b000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b010001) begin
            errors++;
            $display("FAIL midreset_orphan outs got %b want %b", outs, 6'b010001);
        end
        tick();
        idle_inputs();
    endtask

    // Random legal sources (valid held until accepted) with occasional orphan flits.
    task automatic test_random();
        bit         vld [2];
        bit         fst [2];
        bit         lst [2];
        int         rem [2];
        bit         req [2];
        bit         e_rdy [2];
        bit         e_sel [2];
        bit         e_ov, e_err, oready;
        int         owner, streak, win;
        logic [5:0] exp;
        do_reset();
        owner  = -1;
        streak = 0;
        for (int s = 0; s < 2; s++) begin
            vld[s] = 0; fst[s] = 0; lst[s] = 0; rem[s] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (!vld[s] && $urandom_range(0, 3) != 0) begin
                    vld[s] = 1;
                    if (rem[s] > 0) begin
                        rem[s]--;
                        fst[s] = 0;
                        lst[s] = (rem[s] == 0);
                    end else if ($urandom_range(0, 15) == 0) begin
                        fst[s] = 0;
                        lst[s] = 1'($urandom_range(0, 1));
                    end else begin
                        rem[s] = $urandom_range(0, 2);
                        fst[s] = 1;
                        lst[s] = (rem[s] == 0);
                    end
                end
            end
            oready = ($urandom_range(0, 3) != 0);
            drive(vld[0], fst[0], lst[0], vld[1], fst[1], lst[1], oready);
            #1;
            e_ov = 0; e_err = 0;
            for (int s = 0; s < 2; s++) begin
                e_rdy[s] = 0; e_sel[s] = 0; req[s] = vld[s] && fst[s];
            end
            if (owner < 0) begin
                win = -1;
                if (req[0] && (!req[1] || streak < RING_BURST)) win = 0;
                else if (req[1]) win = 1;
                if (win >= 0) begin
                    e_sel[win] = 1;
                    e_ov       = 1;
                    e_rdy[win] = oready;
                    if (win == 1) streak = 0;
                    else if (req[1] && streak < RING_BURST) streak++;
                    owner = (lst[win] && oready) ? -1 : win;
                end else if (vld[0]) begin
                    e_rdy[0] = 1; e_err = 1;
                end else if (vld[1]) begin
                    e_rdy[1] = 1; e_err = 1;
                end
            end else begin
                win        = owner;
                e_sel[win] = 1;
                e_ov       = vld[win];
                e_rdy[win] = oready;
                if (vld[win] && lst[win] && oready) owner = -1;
            end
            exp = {e_ov, e_rdy[0], e_rdy[1], e_sel[0], e_sel[1], e_err};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL random cycle%0d outs got %b want %b", cyc, outs, exp);
            end
            for (int s = 0; s < 2; s++) begin
                if (vld[s] && e_rdy[s]) vld[s] = 0;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

`ifdef RING_ROUTER_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0, 0, 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 1, 1, 1);
            tick();
        end
        idle_inputs();
        checks++;
        if ({stat_ring_worms, stat_local_worms} !== {2'd3, 2'd2}) begin
            errors++;
            $display("FAIL stats_count got %0d/%0d want 3/2", stat_ring_worms, stat_local_worms);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        checks++;
        if ({stat_ring_worms, stat_local_worms} !== 4'b0000) begin
            errors++;
            $display("FAIL stats_clear got %0d/%0d want 0/0", stat_ring_worms, stat_local_worms);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 0, 0, 1);
            tick();
        end
        idle_inputs();
        checks++;
        if (stat_ring_worms !== 2'd3) begin
            errors++;
            $display("FAIL stats_saturate got %0d want 3", stat_ring_worms);
        end
        drive(0, 0, 0, 1, 1, 1, 1);
        stat_clr = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({stat_ring_worms, stat_local_worms} !== 4'b0000) begin
            errors++;
            $display("FAIL stats_clear_wins got %0d/%0d want 0/0",
                     stat_ring_worms, stat_local_worms);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_ring_worm();
        test_burst_order();
        test_backpressure();
        test_orphan();
        test_midworm_reset();
        test_random();
`ifdef RING_ROUTER_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
